eight_bit_down_timer: RTL and testbench
=======================================

// Module: eight_bit_down_timer
// PURPOSE
//   Loadable down-counter/timer: counts a loaded value down to zero on en
//   strobes and flags terminal count (tc). Paired with the up counter with load
//   as its count-down companion: timeouts, periodic ticks, frame/burst length
//   counting. One-shot or periodic (auto-reload) mode, single clock domain.
// PARAMETERS
//   WIDTH   8   counter, data and reload register width in bits
// PORTS
//   clk    in   1      rising-edge clock, sole clock
//   rst    in   1      reset: asynchronous assert, active-low (0 = reset)
//   en     in   1      count enable; one decrement per cycle when high
//   load   in   1      load data into counter and reload register
//   mode   in   1      0 = one-shot, 1 = periodic auto-reload
//   data   in   WIDTH  load value
//   out    out  WIDTH  current count (registered)
//   tc     out  1      terminal-count pulse (registered, 1 cycle per event)
//   busy   out  1      1 while in RUN state (decoded from state register)
// BEHAVIOUR
//   Reset (rst=0, async): out=0, reload_q=0, tc=0, state=IDLE, busy=0.
//   States: IDLE (halted, en ignored), RUN (counting).
//   Priority per clock edge: load > en > hold.
//   load=1: out<=data, reload_q<=data, tc<=0; state<=RUN if data!=0 else IDLE.
//     load wins over en in the same cycle (no decrement that cycle).
//     load during RUN restarts the count from data, with no tc.
//   RUN, en=1, out>1: out<=out-1, tc<=0.
//   RUN, en=1, out==1 (terminal event): tc<=1 on this edge;
//     mode=0: out<=0, state<=IDLE.
//     mode=1: out<=reload_q, stay RUN -> period = reload_q en-strobes.
//     mode sampled only at the terminal event; changing it mid-count is legal.
//   RUN, en=0: out, state hold; tc<=0.
//   IDLE: out holds (0 after one-shot, or last loaded value if load data=0);
//     en has no effect; tc<=0. Only load leaves IDLE.
//   Never decrements from 0; no underflow/wrap. load of 0 -> IDLE, no tc.
//   reload_q=1 in periodic mode: tc high on every en cycle, out stays 1.
//   Latency: out and tc update on the edge that samples load/en (1 cycle).
//   tc is high only in the cycle following a terminal event; back-to-back
//     terminal events give back-to-back tc cycles.
//   Reset mid-count: immediate return to reset values; no tc generated.
//   All arithmetic is unsigned WIDTH bits.
// STRUCTURE
//   Single module; no sub-module needed (state reg + counter + reload reg).
//   Shared header counter_defs.vh: state encodings ST_IDLE=1'b0, ST_RUN=1'b1,
//     MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1. Same header also used by the up
//     counter.
//   Two always blocks: async-reset sequential (state, out, reload_q, tc);
//     combinational next-state/next-count.
// TESTING
//   1 Reset: assert rst=0 mid-cycle with out=8'h37 -> out=0, tc=0, busy=0
//     immediately (async), held until release.
//   2 One-shot: load data=3, mode=0, en=1 continuous -> out 3,2,1,0; tc=1 only
//     in the cycle out becomes 0; busy drops then; further en leaves out=0.
//   3 Periodic: load 4, mode=1, en=1 -> out 4,3,2,1,4,3,...; tc every 4th
//     cycle; en toggled 50% -> tc every 8 clocks, out holds while en=0.
//   4 Collisions: load=1 and en=1 with data=8'hFF -> out=FF (no decrement);
//     load 5 during RUN at out=2 -> out=5, no tc.
//   5 Edges: load 0 -> IDLE, out=0, no tc, en ignored; periodic reload 1 ->
//     tc every en cycle; WIDTH=4 build, load 4'hF, one-shot -> tc after 15.
//   6 Random: constrained-random load/en/mode vs a reference model,
//     checking out/tc/busy every cycle, including async resets.

Source files
------------

// File: rtl/eight_bit_down_timer_pkg.sv
// Shared encodings for the down timer: FSM states and auto-reload mode values.
package eight_bit_down_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/eight_bit_down_timer_if.sv
// Control/status bundle of the down timer; master drives load/en/mode/data.
// Handshake: no valid/ready; load and en are sampled on every rising clk edge.
interface eight_bit_down_timer_if #(
  parameter int WIDTH = eight_bit_down_timer_pkg::DEFAULT_WIDTH
);
  import eight_bit_down_timer_pkg::*;

  logic             en;
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;
  state_e           state;

  modport master (
    output en, load, mode, data,
    input  out, tc, busy, state
  );

  modport slave (
    input  en, load, mode, data,
    output out, tc, busy, state
  );

endinterface

// File: rtl/eight_bit_down_timer.sv
// Loadable down-counter with terminal-count pulse, one-shot or auto-reload.
// Priority on each edge: load, then en, then hold.
module eight_bit_down_timer
  import eight_bit_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  eight_bit_down_timer_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // In RUN the count is never zero, so reaching one is the only terminal event.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      out_d    = bus.data;
      reload_d = bus.data;
      state_d  = (bus.data != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && bus.en) begin
      if (out_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (bus.mode == MODE_PERIODIC) begin
          out_d = reload_q;
        end else begin
          out_d   = '0;
          state_d = ST_IDLE;
        end
      end else begin
        out_d = out_q - WIDTH'(1);
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.state = state_q;

endmodule

// File: tb/tb_eight_bit_down_timer.sv
// Self-checking bench for eight_bit_down_timer: vector table, corner sequences,
// random stimulus against a behavioural model, and a 4-bit build.
module tb_eight_bit_down_timer;
  import eight_bit_down_timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eight_bit_down_timer_if #(.WIDTH(8)) bus8 ();
  eight_bit_down_timer_if #(.WIDTH(4)) bus4 ();

  eight_bit_down_timer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  eight_bit_down_timer #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int m_count  = 0;
  int m_reload = 0;
  bit m_run    = 1'b0;
  bit m_tc     = 1'b0;

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_run = 1'b0; m_tc = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit l, input bit m, input int d);
    m_tc = 1'b0;
    if (l) begin
      m_count  = d;
      m_reload = d;
      m_run    = (d != 0);
    end else if (m_run && e) begin
      if (m_count - 1 == 0) begin
        m_tc = 1'b1;
        if (m) m_count = m_reload;
        else begin m_count = 0; m_run = 1'b0; end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},  32'(bus8.out), 32'(m_count));
    check({tag, ".tc"},   32'(bus8.tc),  32'(m_tc));
    check({tag, ".busy"}, 32'(bus8.busy), 32'(m_run));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input bit e, input bit l, input bit m, input logic [7:0] d);
    bus8.en = e; bus8.load = l; bus8.mode = m; bus8.data = d;
    @(posedge clk);
    model_edge(e, l, m, int'(d));
    #1;
  endtask

  // Asserts reset a few ns after an edge, checks async clear and hold, releases.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model({tag, ".async"});
    bus8.en = 1'b0; bus8.load = 1'b0; bus8.mode = 1'b0; bus8.data = '0;
    @(posedge clk); #1;
    check_model({tag, ".held"});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b0, 1'b0, 0);
    #1;
  endtask

  typedef struct {
    bit         en;
    bit         load;
    bit         mode;
    logic [7:0] data;
    logic [7:0] exp_out;
    bit         exp_tc;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int tc_seen;
    int strobes;

    bus8.en = 1'b0; bus8.load = 1'b0; bus8.mode = 1'b0; bus8.data = '0;
    bus4.en = 1'b0; bus4.load = 1'b0; bus4.mode = 1'b0; bus4.data = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.out",  32'(bus8.out), 32'h0);
    check("reset.tc",   32'(bus8.tc), 32'h0);
    check("reset.busy", 32'(bus8.busy), 32'h0);
    check("reset.state", 32'(bus8.state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- vector table ----------------
    //          en  ld  md  data   out   tc busy
    vecs.push_back('{1, 1, 0, 8'd3,  8'd3,  0, 1}); // one-shot load 3
    vecs.push_back('{1, 0, 0, 8'd0,  8'd2,  0, 1});
    vecs.push_back('{1, 0, 0, 8'd0,  8'd1,  0, 1});
    vecs.push_back('{1, 0, 0, 8'd0,  8'd0,  1, 0}); // terminal
    vecs.push_back('{1, 0, 0, 8'd0,  8'd0,  0, 0}); // en ignored in IDLE
    vecs.push_back('{1, 1, 0, 8'hFF, 8'hFF, 0, 1}); // load beats en
    vecs.push_back('{1, 0, 0, 8'd0,  8'hFE, 0, 1});
    vecs.push_back('{0, 0, 0, 8'd0,  8'hFE, 0, 1}); // hold
    vecs.push_back('{0, 1, 0, 8'd2,  8'd2,  0, 1});
    vecs.push_back('{1, 1, 0, 8'd5,  8'd5,  0, 1}); // restart at out=2
    vecs.push_back('{1, 1, 0, 8'd0,  8'd0,  0, 0}); // load 0 -> IDLE
    vecs.push_back('{1, 0, 0, 8'd0,  8'd0,  0, 0});
    vecs.push_back('{0, 1, 1, 8'd1,  8'd1,  0, 1}); // periodic reload 1
    vecs.push_back('{1, 0, 1, 8'd0,  8'd1,  1, 1});
    vecs.push_back('{1, 0, 1, 8'd0,  8'd1,  1, 1});
    vecs.push_back('{0, 0, 1, 8'd0,  8'd1,  0, 1});
    vecs.push_back('{0, 1, 1, 8'd4,  8'd4,  0, 1}); // periodic 4
    vecs.push_back('{1, 0, 1, 8'd0,  8'd3,  0, 1});
    vecs.push_back('{1, 0, 1, 8'd0,  8'd2,  0, 1});
    vecs.push_back('{1, 0, 1, 8'd0,  8'd1,  0, 1});
    vecs.push_back('{1, 0, 1, 8'd0,  8'd4,  1, 1});
    vecs.push_back('{1, 0, 1, 8'd0,  8'd3,  0, 1});

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].load, vecs[i].mode, vecs[i].data);
      check($sformatf("vec%0d.out", i),  32'(bus8.out),  32'(vecs[i].exp_out));
      check($sformatf("vec%0d.tc", i),   32'(bus8.tc),   32'(vecs[i].exp_tc));
      check($sformatf("vec%0d.busy", i), 32'(bus8.busy), 32'(vecs[i].exp_busy));
    end

    // ---------------- periodic with 50% en: tc every 8 clocks ----------------
    step(1'b0, 1'b1, 1'b1, 8'd4);
    tc_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(i[0] == 1'b0, 1'b0, 1'b1, 8'd0);
      check_model($sformatf("half%0d", i));
      if (bus8.tc) begin
        tc_seen++;
        check("half.tc_pos", 32'(i % 8), 32'd6);
      end
    end
    check("half.tc_count", 32'(tc_seen), 32'd2);

    // ---------------- async reset mid-count at 0x37 ----------------
    step(1'b0, 1'b1, 1'b0, 8'h37);
    check("pre_rst.out", 32'(bus8.out), 32'h37);
    async_reset("rst37");
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check_model("post_rst");

    // ---------------- randomized vs model ----------------
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        bit e, l, m;
        logic [7:0] d;
        e = ($urandom_range(0, 9) < 7);
        l = ($urandom_range(0, 9) == 0);
        m = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
          0: d = 8'd0;
          1: d = 8'(1 + $urandom_range(0, 1));
          2: d = 8'($urandom_range(0, 12));
          default: d = 8'($urandom_range(0, 255));
        endcase
        step(e, l, m, d);
        check_model("rnd");
      end
    end

    // ---------------- 4-bit build: load F, one-shot ----------------
    bus8.en = 1'b0; bus8.load = 1'b0;
    bus4.load = 1'b1; bus4.en = 1'b1; bus4.mode = MODE_ONESHOT; bus4.data = 4'hF;
    @(posedge clk); #1;
    check("w4.load_out", 32'(bus4.out), 32'hF);
    bus4.load = 1'b0;
    strobes = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus4.tc && strobes == 0) strobes = i;
    end
    check("w4.tc_after", 32'(strobes), 32'd15);
    check("w4.final_out", 32'(bus4.out), 32'h0);
    check("w4.final_busy", 32'(bus4.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Whole-run watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
